// File: rtl/result_uart_reporter.sv
// ---------------------------------------------------------------------------
// result_uart_reporter
//
// Purpose:
//    Waits for the rising edge of the solver's done level, latches the result,
//    converts it to decimal with a serial double-dabble, then transmits the
//    digits (leading zeros suppressed) followed by CR LF on a UART 8N1 line.
//
// Ports:
//    clk      in   system clock, all logic on the rising edge
//    rst      in   asynchronous, active-high reset
//    result   in   RESULT_W-bit unsigned answer, sampled only on trigger
//    done     in   solver completion level; its rising edge is the trigger
//    uart_tx  out  registered serial output, idle high
//    busy     out  high from the cycle after trigger until the last stop bit
//    sent     out  one-cycle pulse when the final LF stop bit completes
// ---------------------------------------------------------------------------
module result_uart_reporter #(
   parameter int CLKS_PER_BIT = 104,
   parameter int RESULT_W     = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [RESULT_W-1:0] result,
   input  logic                done,
   output logic                uart_tx,
   output logic                busy,
   output logic                sent
);

   localparam int NDIG  = 10;
   localparam int BCD_W = NDIG * 4;
   localparam int CNT_W = $clog2(RESULT_W + 1);
   localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_LOAD,
      S_SEND
   } state_t;

   // Byte phases: digits, CR, LF, and "LF already in the shifter".
   localparam logic [1:0] PH_DIG  = 2'd0;
   localparam logic [1:0] PH_CR   = 2'd1;
   localparam logic [1:0] PH_LF   = 2'd2;
   localparam logic [1:0] PH_LAST = 2'd3;

   state_t              r_state;
   logic                r_done_q;
   logic [RESULT_W-1:0] r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [CNT_W-1:0]    r_conv_cnt;
   logic                r_first;
   logic [3:0]          r_dig_idx;
   logic [1:0]          r_phase;
   logic [7:0]          r_shift;
   logic [3:0]          r_bit_cnt;
   logic [CLK_W-1:0]    r_clk_cnt;
   logic                r_tx;
   logic                r_busy;
   logic                r_sent;

   logic [BCD_W-1:0]    w_adj;
   logic [3:0]          w_msd;
   logic [3:0]          w_idx;
   logic [3:0]          w_nib;
   logic [7:0]          w_byte;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
         assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                              : r_bcd[gi*4 +: 4];
      end
   endgenerate

   // Index of the most significant nonzero digit (0 when the value is 0,
   // which makes a zero result print as a single '0').
   always_comb begin
      w_msd = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (r_bcd[i*4 +: 4] != 4'd0) begin
            w_msd = 4'(i);
         end
      end
   end

   assign w_idx = r_first ? w_msd : r_dig_idx;
   assign w_nib = r_bcd[{w_idx, 2'b00} +: 4];

   always_comb begin
      w_byte = 8'h0A;
      case (r_phase)
         PH_DIG:  w_byte = {4'h3, w_nib};
         PH_CR:   w_byte = 8'h0D;
         default: w_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_done_q   <= 1'b0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_conv_cnt <= '0;
         r_first    <= 1'b0;
         r_dig_idx  <= '0;
         r_phase    <= PH_DIG;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_clk_cnt  <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_sent     <= 1'b0;
      end else begin
         r_done_q <= done;
         r_sent   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (done && !r_done_q) begin
                  r_bin      <= result;
                  r_bcd      <= '0;
                  r_conv_cnt <= '0;
                  r_first    <= 1'b1;
                  r_dig_idx  <= '0;
                  r_phase    <= PH_DIG;
                  r_busy     <= 1'b1;
                  r_state    <= S_CONV;
               end
            end

            S_CONV: begin
               {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
               if (r_conv_cnt == CNT_W'(RESULT_W - 1)) begin
                  r_state <= S_LOAD;
               end else begin
                  r_conv_cnt <= r_conv_cnt + 1'b1;
               end
            end

            S_LOAD: begin
               // Start bit goes on the line at this edge.
               r_tx      <= 1'b0;
               r_shift   <= w_byte;
               r_bit_cnt <= '0;
               r_clk_cnt <= '0;
               r_first   <= 1'b0;
               r_state   <= S_SEND;
               case (r_phase)
                  PH_DIG: begin
                     if (w_idx == 4'd0) begin
                        r_phase <= PH_CR;
                     end else begin
                        r_dig_idx <= w_idx - 4'd1;
                     end
                  end
                  PH_CR:   r_phase <= PH_LF;
                  default: r_phase <= PH_LAST;
               endcase
            end

            S_SEND: begin
               if (r_bit_cnt == 4'd9) begin
                  if (r_phase == PH_LAST) begin
                     if (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
                        r_state <= S_IDLE;
                        r_sent  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                     end
                  end else if (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 2)) begin
                     // The LOAD cycle supplies the final stop-bit cycle, so
                     // the next start bit follows back-to-back.
                     r_state <= S_LOAD;
                  end else begin
                     r_clk_cnt <= r_clk_cnt + 1'b1;
                  end
               end else if (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
                  // Shifting ones in from the top turns bit 9 into the stop bit.
                  r_clk_cnt <= '0;
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b1, r_shift[7:1]};
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign uart_tx = r_tx;
   assign busy    = r_busy;
   assign sent    = r_sent;

endmodule

// File: tb/tb_result_uart_reporter.sv
// ---------------------------------------------------------------------------
// tb_result_uart_reporter
//
// Scoreboard bench: stimulus pushes the expected byte stream, frame length
// and trigger cycle of each message; a monitor decodes the UART line every
// cycle and pops/compares as bytes and sent pulses appear.
// ---------------------------------------------------------------------------
module tb_result_uart_reporter;

   localparam int CPB   = 8;
   localparam int RW    = 32;
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] result;
   logic          done;
   logic          uart_tx;
   logic          busy;
   logic          sent;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         len_q[$];
   int         trig_q[$];
   int         sent_cnt  = 0;
   int         exp_sent  = 0;

   // monitor state
   bit         rx_active = 0;
   int         rx_n      = 0;
   logic [9:0] rx_bits;
   bit         rx_ok;
   bit         in_msg    = 0;
   int         msg_start = 0;
   int         msg_bytes = 0;

   result_uart_reporter #(
      .CLKS_PER_BIT(CPB),
      .RESULT_W    (RW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .result (result),
      .done   (done),
      .uart_tx(uart_tx),
      .busy   (busy),
      .sent   (sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_le(input string name, input longint act, input longint lim);
      total++;
      if (act > lim) begin
         bad++;
         $display("FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, lim, $time);
      end
   endtask

   // Reference model: decimal text by repeated division, then CR LF.
   function automatic void model(input logic [31:0] v);
      int          dig[$];
      logic [31:0] t;
      t = v;
      if (t == 0) dig.push_back(0);
      while (t != 0) begin
         dig.push_front(int'(t % 10));
         t = t / 10;
      end
      foreach (dig[i]) exp_q.push_back(8'h30 + 8'(dig[i]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      len_q.push_back((dig.size() + 2) * FRAME);
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst) begin
            rx_active = 0;
         end else begin
            if (!rx_active && uart_tx == 1'b0) begin
               rx_active = 1;
               rx_n      = 0;
               rx_ok     = 1;
               if (!in_msg) begin
                  in_msg    = 1;
                  msg_start = cyc;
                  msg_bytes = 0;
                  if (trig_q.size() == 0) check("unexpected_start", 1, 0);
                  else check_le("start_latency", cyc - trig_q.pop_front(), RW + 4);
               end
            end
            if (rx_active) begin
               if (rx_n % CPB == 0) rx_bits[rx_n / CPB] = uart_tx;
               else if (uart_tx !== rx_bits[rx_n / CPB]) rx_ok = 0;
               rx_n++;
               if (rx_n == FRAME) begin
                  rx_active = 0;
                  msg_bytes++;
                  check("framing", {31'd0, rx_ok && rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1}, 1);
                  if (exp_q.size() == 0) check("unexpected_byte", rx_bits[8:1], -1);
                  else check("rx_byte", rx_bits[8:1], exp_q.pop_front());
               end
            end
            if (sent) begin
               sent_cnt++;
               if (len_q.size() == 0) begin
                  check("unexpected_sent", 1, 0);
               end else begin
                  check("frame_len", cyc - msg_start, len_q.pop_front());
               end
               check("bytes_left_at_sent", exp_q.size(), 0);
               check("busy_at_sent", busy, 0);
               $display("message %0d sent: %0d bytes, %0d cycles of line activity",
                        sent_cnt, msg_bytes, cyc - msg_start);
               in_msg = 0;
            end
         end
      end
   endtask

   task automatic flush();
      exp_q.delete();
      len_q.delete();
      trig_q.delete();
      in_msg    = 0;
      msg_bytes = 0;
   endtask

   task automatic trigger(input logic [31:0] v);
      @(negedge clk);
      done   = 1'b0;
      result = v;
      @(negedge clk);
      done = 1'b1;
      model(v);
      trig_q.push_back(cyc + 1);
      exp_sent++;
      @(negedge clk);
      check("busy_after_trigger", busy, 1);
   endtask

   task automatic wait_sent(input int budget);
      int n;
      n = 0;
      while (sent_cnt < exp_sent && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("completion", sent_cnt, exp_sent);
      if (sent_cnt != exp_sent) begin
         exp_sent = sent_cnt;
         flush();
      end
   endtask

   localparam int BUDGET = 12 * FRAME + 200;

   initial begin
      rst    = 1'b1;
      done   = 1'b0;
      result = '0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      check("reset_uart_tx", uart_tx, 1);
      check("reset_busy", busy, 0);
      check("reset_sent", sent, 0);
      rst = 1'b0;

      // basic values
      trigger(32'd1424);
      wait_sent(BUDGET);
      trigger(32'd0);
      wait_sent(BUDGET);
      trigger(32'hFFFF_FFFF);
      wait_sent(BUDGET);
      trigger(32'd1000000);
      wait_sent(BUDGET);

      // done held high with an extra pulse while busy: one transmission only
      trigger(32'd1424);
      repeat (300) @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
      done = 1'b1;
      wait_sent(BUDGET);
      repeat (5000 - 300) @(negedge clk);
      check("held_done_single", sent_cnt, exp_sent);
      trigger(32'd1424);
      wait_sent(BUDGET);

      // result changes right after trigger
      trigger(32'd1424);
      result = 32'd7;
      wait_sent(BUDGET);

      // asynchronous reset during the second byte's data bits
      begin
         int n;
         trigger(32'd98765);
         n = 0;
         while (!(msg_bytes == 1 && rx_active && rx_n >= 2 * CPB) && n < BUDGET) begin
            @(negedge clk);
            n++;
         end
         check("reached_second_byte", msg_bytes, 1);
         #2 rst = 1'b1;
         #1;
         check("async_rst_uart_tx", uart_tx, 1);
         check("async_rst_busy", busy, 0);
         check("async_rst_sent", sent, 0);
         exp_sent--;
         flush();
         done = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         trigger(32'd2024);
         wait_sent(BUDGET);
      end

      // done already high when reset is released
      @(negedge clk);
      #2 rst = 1'b1;
      done   = 1'b1;
      result = 32'd42;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model(32'd42);
      trig_q.push_back(cyc + 1);
      exp_sent++;
      @(negedge clk);
      check("busy_after_reset_trigger", busy, 1);
      wait_sent(BUDGET);

      // randomized values of varied digit counts
      for (int k = 0; k < 12; k++) begin
         logic [31:0] v;
         v = $urandom >> $urandom_range(0, 31);
         trigger(v);
         if ($urandom_range(0, 1) == 1) result = $urandom;
         wait_sent(BUDGET);
      end

      repeat (20) @(negedge clk);
      check("sent_count", sent_cnt, exp_sent);
      check("leftover_bytes", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
